// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave backed by a word-addressed register memory.
// Owns addresses LOW_ADDR..HIGH_ADDR; out-of-range or oversize transfers
// get a two-cycle ERROR response; OKAY transfers take WAIT_STATES waits.
// Ports:
//   HCLK, HRESET        clock, async active-high reset
//   HSEL, HADDR, HTRANS,
//   HWRITE, HSIZE,
//   HBURST, HREADY      address phase inputs (HBURST unused)
//   HWDATA              write data, sampled in the completion cycle
//   HREADYOUT, HRESP,
//   HRDATA              slave response
module ahb_slave_mem #(
    parameter logic [31:0] LOW_ADDR    = 32'd0,
    parameter logic [31:0] HIGH_ADDR   = 32'd31,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA
);

    localparam int unsigned DEPTH = HIGH_ADDR - LOW_ADDR + 32'd1;
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t r_state;
    state_t w_next;
    state_t w_route;

    logic [2:0]    r_wcnt;
    logic [AW-1:0] r_idx;
    logic          r_write;
    logic [2:0]    r_size;
    logic [31:0]   r_mem [DEPTH];

    logic          w_accept;
    logic          w_eval;
    logic          w_take;
    logic          w_err;
    logic [31:0]   w_off;
    logic [31:0]   w_wmerge;
    logic          w_unused;

    // HTRANS[1] set means NONSEQ or SEQ
    assign w_accept = HSEL & HREADY & HTRANS[1];
    assign w_err    = (HADDR < LOW_ADDR) | (HADDR > HIGH_ADDR)
                    | (HSIZE > 3'd2);
    assign w_off    = HADDR - LOW_ADDR;

    // Address phases are only looked at in cycles where HREADYOUT is high
    assign w_eval = (r_state == ST_IDLE) | (r_state == ST_DATA)
                  | (r_state == ST_ERR2);
    assign w_take = w_eval & w_accept;

    assign w_unused = ^{HBURST, HTRANS[0], w_off};

    always_comb begin
        if (w_err) begin
            w_route = ST_ERR1;
        end else if (WAIT_STATES > 0) begin
            w_route = ST_WAIT;
        end else begin
            w_route = ST_DATA;
        end
    end

    always_comb begin
        w_next    = r_state;
        HREADYOUT = 1'b1;
        HRESP     = RESP_OKAY;
        HRDATA    = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_take) w_next = w_route;
            end
            ST_WAIT: begin
                HREADYOUT = 1'b0;
                if (r_wcnt <= 3'd1) w_next = ST_DATA;
            end
            ST_DATA: begin
                if (!r_write) HRDATA = r_mem[r_idx];
                w_next = w_take ? w_route : ST_IDLE;
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = RESP_ERROR;
                w_next    = ST_ERR2;
            end
            ST_ERR2: begin
                HRESP  = RESP_ERROR;
                w_next = w_take ? w_route : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state <= ST_IDLE;
            r_wcnt  <= '0;
            r_idx   <= '0;
            r_write <= 1'b0;
            r_size  <= '0;
        end else begin
            r_state <= w_next;
            if (w_take) begin
                r_idx   <= w_err ? '0 : w_off[AW-1:0];
                r_write <= HWRITE;
                r_size  <= HSIZE;
                r_wcnt  <= 3'(WAIT_STATES);
            end else if (r_state == ST_WAIT && r_wcnt != 3'd0) begin
                r_wcnt <= r_wcnt - 3'd1;
            end
        end
    end

    // Narrow writes land in the low lanes; upper bits keep old contents
    always_comb begin
        w_wmerge = HWDATA;
        unique case (r_size)
            3'd0:    w_wmerge = {r_mem[r_idx][31:8], HWDATA[7:0]};
            3'd1:    w_wmerge = {r_mem[r_idx][31:16], HWDATA[15:0]};
            default: w_wmerge = HWDATA;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (r_state == ST_DATA && r_write) begin
            r_mem[r_idx] <= w_wmerge;
        end
    end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: three instances (defaults,
// three wait states, offset window 32..62) on one shared bus.
module tb_ahb_slave_mem;

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NSEQ = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;

    logic        HCLK;
    logic        HRESET;
    logic [2:0]  hsel;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;

    logic        w_ro [3];
    logic [1:0]  w_rr [3];
    logic [31:0] w_rd [3];

    int n_cmp = 0;
    int n_bad = 0;

    ahb_slave_mem u0 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[0]), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(w_ro[0]),
        .HREADYOUT(w_ro[0]), .HRESP(w_rr[0]), .HRDATA(w_rd[0])
    );

    ahb_slave_mem #(.WAIT_STATES(3)) u1 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[1]), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(w_ro[1]),
        .HREADYOUT(w_ro[1]), .HRESP(w_rr[1]), .HRDATA(w_rd[1])
    );

    ahb_slave_mem #(.LOW_ADDR(32'd32), .HIGH_ADDR(32'd62)) u2 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[2]), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(w_ro[2]),
        .HREADYOUT(w_ro[2]), .HRESP(w_rr[2]), .HRDATA(w_rd[2])
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic        sel;
        logic [1:0]  tr;
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        rdy;
        logic [1:0]  rsp;
        logic [31:0] rd;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(
        input logic sel, input logic [1:0] tr, input logic wr,
        input logic [2:0] sz, input logic [31:0] addr,
        input logic [31:0] wd, input logic rdy,
        input logic [1:0] rsp, input logic [31:0] rd);
        vec_t v;
        v.sel = sel; v.tr = tr; v.wr = wr; v.sz = sz; v.addr = addr;
        v.wd = wd; v.rdy = rdy; v.rsp = rsp; v.rd = rd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic [2:0] s, input logic [1:0] tr,
                         input logic wr, input logic [31:0] a,
                         input logic [31:0] wd);
        hsel   = s;
        HTRANS = tr;
        HWRITE = wr;
        HSIZE  = 3'd2;
        HADDR  = a;
        HWDATA = wd;
    endtask

    // One transfer on the 3-wait instance; counts low HREADYOUT cycles
    task automatic ws_xfer(input string nm, input logic wr,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] exp_rd);
        int  lows;
        bit  done;
        bit  bad_rsp;
        drive(3'b010, T_NSEQ, wr, a, 32'h0);
        #4;
        chk({nm, " addr rdy"}, 32'(w_ro[1]), 32'd1);
        tick();
        drive(3'b010, T_IDLE, 1'b0, 32'h0, wd);
        lows    = 0;
        done    = 1'b0;
        bad_rsp = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            #4;
            if (w_rr[1] !== 2'b00) bad_rsp = 1'b1;
            if (w_ro[1] === 1'b1) begin
                done = 1'b1;
                chk({nm, " rdata"}, w_rd[1], exp_rd);
            end else begin
                lows++;
            end
            tick();
        end
        chk({nm, " wait cycles"}, 32'(lows), 32'd3);
        chk({nm, " resp okay"}, 32'(bad_rsp), 32'd0);
    endtask

    initial begin
        HRESET = 1'b1;
        HBURST = 3'd0;
        drive(3'b000, T_IDLE, 1'b0, 32'h0, 32'h0);
        #3;
        chk("reset rdy u0", 32'(w_ro[0]), 32'd1);
        chk("reset rsp u0", 32'(w_rr[0]), 32'd0);
        chk("reset rdata u1", w_rd[1], 32'd0);
        tick();
        tick();
        HRESET = 1'b0;

        // sel tr wr sz addr wdata | rdy rsp rdata
        tv.push_back(mk(1, T_IDLE, 0, 2, 0, 0, 1, 0, 0));
        tv.push_back(mk(1, T_NSEQ, 1, 2, 5, 0, 1, 0, 0));
        tv.push_back(mk(1, T_NSEQ, 0, 2, 5, 32'hDEADBEEF, 1, 0, 0));
        tv.push_back(mk(1, T_IDLE, 0, 2, 0, 0, 1, 0, 32'hDEADBEEF));
        tv.push_back(mk(1, T_IDLE, 0, 2, 0, 0, 1, 0, 0));
        tv.push_back(mk(1, T_NSEQ, 1, 2, 0, 0, 1, 0, 0));
        tv.push_back(mk(1, T_SEQ,  1, 2, 1, 32'h10, 1, 0, 0));
        tv.push_back(mk(1, T_SEQ,  1, 2, 2, 32'h11, 1, 0, 0));
        tv.push_back(mk(1, T_SEQ,  1, 2, 3, 32'h12, 1, 0, 0));
        tv.push_back(mk(1, T_NSEQ, 0, 2, 0, 32'h13, 1, 0, 0));
        tv.push_back(mk(1, T_SEQ,  0, 2, 1, 0, 1, 0, 32'h10));
        tv.push_back(mk(1, T_BUSY, 0, 2, 2, 0, 1, 0, 32'h11));
        tv.push_back(mk(1, T_SEQ,  0, 2, 2, 0, 1, 0, 0));
        tv.push_back(mk(1, T_SEQ,  0, 2, 3, 0, 1, 0, 32'h12));
        tv.push_back(mk(1, T_IDLE, 0, 2, 0, 0, 1, 0, 32'h13));
        tv.push_back(mk(1, T_NSEQ, 1, 1, 5, 0, 1, 0, 0));
        tv.push_back(mk(1, T_NSEQ, 0, 2, 5, 32'h11112222, 1, 0, 0));
        tv.push_back(mk(1, T_IDLE, 0, 2, 0, 0, 1, 0, 32'hDEAD2222));
        tv.push_back(mk(1, T_NSEQ, 1, 0, 5, 0, 1, 0, 0));
        tv.push_back(mk(1, T_NSEQ, 0, 2, 5, 32'hAABBCCDD, 1, 0, 0));
        tv.push_back(mk(1, T_IDLE, 0, 2, 0, 0, 1, 0, 32'hDEAD22DD));
        tv.push_back(mk(1, T_NSEQ, 1, 3, 6, 0, 1, 0, 0));
        tv.push_back(mk(1, T_IDLE, 0, 2, 0, 32'hFFFFFFFF, 0, 1, 0));
        tv.push_back(mk(1, T_NSEQ, 0, 2, 6, 32'hFFFFFFFF, 1, 1, 0));
        tv.push_back(mk(1, T_IDLE, 0, 2, 0, 0, 1, 0, 0));
        tv.push_back(mk(1, T_NSEQ, 0, 2, 40, 0, 1, 0, 0));
        tv.push_back(mk(1, T_IDLE, 0, 2, 0, 0, 0, 1, 0));
        tv.push_back(mk(1, T_IDLE, 0, 2, 0, 0, 1, 1, 0));
        tv.push_back(mk(1, T_IDLE, 0, 2, 0, 0, 1, 0, 0));
        tv.push_back(mk(0, T_NSEQ, 1, 2, 5, 0, 1, 0, 0));
        tv.push_back(mk(1, T_NSEQ, 0, 2, 5, 32'h0BADF00D, 1, 0, 0));
        tv.push_back(mk(1, T_IDLE, 0, 2, 0, 0, 1, 0, 32'hDEAD22DD));

        foreach (tv[i]) begin
            hsel   = {2'b00, tv[i].sel};
            HTRANS = tv[i].tr;
            HWRITE = tv[i].wr;
            HSIZE  = tv[i].sz;
            HADDR  = tv[i].addr;
            HWDATA = tv[i].wd;
            #4;
            chk($sformatf("v%0d rdy", i), 32'(w_ro[0]), 32'(tv[i].rdy));
            chk($sformatf("v%0d rsp", i), 32'(w_rr[0]), 32'(tv[i].rsp));
            chk($sformatf("v%0d rdata", i), w_rd[0], tv[i].rd);
            tick();
        end

        // Three wait states: write then read back addr 10
        ws_xfer("ws write10", 1'b1, 32'd10, 32'hCAFEF00D, 32'h0);
        ws_xfer("ws read10", 1'b0, 32'd10, 32'h0, 32'hCAFEF00D);

        // Offset window: write above HIGH_ADDR errors, memory untouched
        drive(3'b100, T_NSEQ, 1'b1, 32'd63, 32'h0);
        #4;
        chk("err63 addr rdy", 32'(w_ro[2]), 32'd1);
        tick();
        drive(3'b100, T_IDLE, 1'b0, 32'h0, 32'h1);
        #4;
        chk("err63 err1 rdy", 32'(w_ro[2]), 32'd0);
        chk("err63 err1 rsp", 32'(w_rr[2]), 32'd1);
        chk("err63 err1 rdata", w_rd[2], 32'd0);
        tick();
        #4;
        chk("err63 err2 rdy", 32'(w_ro[2]), 32'd1);
        chk("err63 err2 rsp", 32'(w_rr[2]), 32'd1);
        tick();
        drive(3'b100, T_NSEQ, 1'b0, 32'd62, 32'h0);
        tick();
        drive(3'b100, T_IDLE, 1'b0, 32'h0, 32'h0);
        #4;
        chk("read62 rdy", 32'(w_ro[2]), 32'd1);
        chk("read62 rsp", 32'(w_rr[2]), 32'd0);
        chk("read62 rdata", w_rd[2], 32'd0);
        tick();
        drive(3'b100, T_NSEQ, 1'b1, 32'd32, 32'h0);
        tick();
        drive(3'b100, T_NSEQ, 1'b0, 32'd32, 32'h12345678);
        tick();
        drive(3'b100, T_IDLE, 1'b0, 32'h0, 32'h0);
        #4;
        chk("rw32 rdata", w_rd[2], 32'h12345678);
        tick();

        // Reset during a wait-stated write to addr 7
        drive(3'b010, T_NSEQ, 1'b1, 32'd7, 32'h0);
        tick();
        drive(3'b010, T_IDLE, 1'b0, 32'h0, 32'h77777777);
        #4;
        chk("rst7 wait rdy", 32'(w_ro[1]), 32'd0);
        #2;
        HRESET = 1'b1;
        #1;
        chk("rst7 async rdy", 32'(w_ro[1]), 32'd1);
        chk("rst7 async rsp", 32'(w_rr[1]), 32'd0);
        chk("rst7 async rdata", w_rd[1], 32'd0);
        tick();
        HRESET = 1'b0;
        ws_xfer("rst7 read7", 1'b0, 32'd7, 32'h0, 32'h0);
        ws_xfer("rst7 read10", 1'b0, 32'd10, 32'h0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
